// File: rtl/madd_err_monitor.sv
// madd_err_monitor: checks an approximate 6-in/4-out multiply-add against exact a*b+c
// and accumulates error statistics over a window of NUM_SAMPLES accepted samples.
// Ports: clk, rst_n (async low); start pulse opens a window from IDLE/DONE;
//   in_valid/in_ready handshake carries in_vec {c,b,a} and approx;
//   busy (RUN/DRAIN), done (DONE), pass (no violations, valid in DONE);
//   sample_cnt, viol_cnt, max_err, err_sum: saturating window statistics.
module madd_err_monitor #(
   parameter int ET          = 2,
   parameter int NUM_SAMPLES = 64,
   parameter int CNT_W       = 16,
   parameter int SUM_W       = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_vec,
   input  logic [3:0]       approx,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [3:0]       max_err,
   output logic [SUM_W-1:0] err_sum
);

   localparam int ACC_W = $clog2(NUM_SAMPLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] accepted;
   logic             s1_v;
   logic [3:0]       s1_approx;
   logic [3:0]       s1_exact;

   logic             fire;
   logic             last;
   logic [3:0]       exact_c;
   logic [3:0]       err_c;
   logic [SUM_W:0]   sum_ext;

   assign in_ready = (state == RUN) &&
                     (accepted < ACC_W'(NUM_SAMPLES));
   assign fire     = in_valid && in_ready;
   assign last     = (accepted == ACC_W'(NUM_SAMPLES - 1));
   assign busy     = (state == RUN) || (state == DRAIN);
   assign done     = (state == DONE);

   assign exact_c = 4'(in_vec[1:0]) * 4'(in_vec[3:2])
                  + 4'(in_vec[5:4]);

   assign err_c = (s1_approx >= s1_exact) ?
                  (s1_approx - s1_exact) :
                  (s1_exact - s1_approx);

   // One extra bit so a carry out flags saturation.
   assign sum_ext = {1'b0, err_sum}
                  + {{(SUM_W - 3){1'b0}}, err_c};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         accepted   <= '0;
         s1_v       <= 1'b0;
         s1_approx  <= '0;
         s1_exact   <= '0;
         pass       <= 1'b0;
         sample_cnt <= '0;
         viol_cnt   <= '0;
         max_err    <= '0;
         err_sum    <= '0;
      end else begin
         s1_v <= fire;
         if (fire) begin
            s1_approx <= approx;
            s1_exact  <= exact_c;
         end

         if (s1_v) begin
            if (sample_cnt != '1)
               sample_cnt <= sample_cnt + 1'b1;
            if ((32'(err_c) > ET) && (viol_cnt != '1))
               viol_cnt <= viol_cnt + 1'b1;
            if (err_c > max_err)
               max_err <= err_c;
            err_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
         end

         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RUN;
                  accepted   <= '0;
                  pass       <= 1'b0;
                  sample_cnt <= '0;
                  viol_cnt   <= '0;
                  max_err    <= '0;
                  err_sum    <= '0;
               end
            end
            RUN: begin
               if (fire) begin
                  accepted <= accepted + 1'b1;
                  if (last)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               // Last sample sits in S1 for one cycle, then retires.
               if (!s1_v) begin
                  state <= DONE;
                  pass  <= (viol_cnt == '0);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_madd_err_monitor.sv
// tb_madd_err_monitor: directed bench for madd_err_monitor
// exhaustive sweeps, gaps, mid-window reset and saturation window.
module tb_madd_err_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, in_valid, in_ready;
   logic [5:0]  in_vec;
   logic [3:0]  approx;
   logic        busy, done, pass;
   logic [15:0] sample_cnt, viol_cnt;
   logic [3:0]  max_err;
   logic [19:0] err_sum;

   logic        start2, in_valid2, in_ready2;
   logic [5:0]  in_vec2;
   logic [3:0]  approx2;
   logic        busy2, done2, pass2;
   logic [15:0] sample_cnt2, viol_cnt2;
   logic [3:0]  max_err2;
   logic [19:0] err_sum2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   madd_err_monitor dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .approx(approx),
      .busy(busy), .done(done), .pass(pass),
      .sample_cnt(sample_cnt), .viol_cnt(viol_cnt),
      .max_err(max_err), .err_sum(err_sum)
   );

   madd_err_monitor #(.NUM_SAMPLES(70000)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .in_vec(in_vec2), .approx(approx2),
      .busy(busy2), .done(done2), .pass(pass2),
      .sample_cnt(sample_cnt2), .viol_cnt(viol_cnt2),
      .max_err(max_err2), .err_sum(err_sum2)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] exact_of(input logic [5:0] v);
      return 4'(v[1:0]) * 4'(v[3:2]) + 4'(v[5:4]);
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present one sample and return just after the edge that took it.
   task automatic send(input logic [5:0] v, input logic [3:0] ap);
      int budget;
      in_vec   = v;
      approx   = ap;
      in_valid = 1'b1;
      budget   = 0;
      while (!in_ready && budget < 50) begin
         step();
         budget++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $error("FAIL ready_timeout: observed 0 expected 1");
      end
      step();
   endtask

   task automatic wait_done();
      int budget;
      budget = 0;
      while (!done && budget < 20) begin
         step();
         budget++;
      end
      chk("done_wait", 32'(done), 32'd1);
   endtask

   // mode 0: exact, 1: zero, 2: exact+2 clamped
   function automatic logic [3:0] ap_of(input int mode,
                                        input logic [5:0] v);
      logic [4:0] e2;
      e2 = 5'(exact_of(v)) + 5'd2;
      if (mode == 0) return exact_of(v);
      if (mode == 1) return 4'd0;
      return (e2 > 5'd15) ? 4'd15 : e2[3:0];
   endfunction

   task automatic sweep(input int mode);
      for (int i = 0; i < 64; i++)
         send(6'(i), ap_of(mode, 6'(i)));
      in_valid = 1'b0;
   endtask

   task automatic chk_stats(input string tag,
                            input int sc, input int vc,
                            input int me, input int es,
                            input int ps);
      chk({tag, "_sample_cnt"}, 32'(sample_cnt), sc);
      chk({tag, "_viol_cnt"},   32'(viol_cnt),   vc);
      chk({tag, "_max_err"},    32'(max_err),    me);
      chk({tag, "_err_sum"},    32'(err_sum),    es);
      chk({tag, "_pass"},       32'(pass),       ps);
   endtask

   initial begin
      int budget;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      in_vec = '0; approx = '0;
      start2 = 1'b0; in_valid2 = 1'b0;
      in_vec2 = 6'h3F; approx2 = 4'd0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_busy",     32'(busy),     0);
      chk("rst_done",     32'(done),     0);
      chk_stats("rst", 0, 0, 0, 0, 0);
      step(); step();
      rst_n = 1'b1;
      step();
      chk("idle_in_ready", 32'(in_ready), 0);

      // Exact sweep with done latency
      pulse_start();
      chk("s1_busy", 32'(busy), 1);
      chk("s1_ready", 32'(in_ready), 1);
      sweep(0);
      chk("s1_ready_after", 32'(in_ready), 0);
      chk("s1_done_c1", 32'(done), 0);
      step();
      chk("s1_done_c2", 32'(done), 0);
      chk("s1_cnt_c2", 32'(sample_cnt), 64);
      step();
      chk("s1_done_c3", 32'(done), 1);
      chk("s1_busy_c3", 32'(busy), 0);
      chk_stats("s1", 64, 0, 0, 0, 1);

      // All-zero approximation
      pulse_start();
      chk("s2_pass_clr", 32'(pass), 0);
      chk("s2_cnt_clr", 32'(sample_cnt), 0);
      sweep(1);
      wait_done();
      chk_stats("s2", 64, 39, 12, 240, 0);

      // Error exactly at threshold
      pulse_start();
      sweep(2);
      wait_done();
      chk_stats("s3", 64, 0, 2, 128, 1);

      // Gaps and ignored start pulses
      pulse_start();
      for (int i = 0; i < 64; i++) begin
         int g;
         g = int'($urandom_range(0, 2));
         for (int k = 0; k < g; k++) begin
            in_valid = 1'b0;
            start = (k == 0) && (i % 5 == 0);
            step();
            start = 1'b0;
         end
         send(6'(i), ap_of(0, 6'(i)));
      end
      chk("s4_ready_after", 32'(in_ready), 0);
      in_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("s4_busy_drain", 32'(busy), 1);
      wait_done();
      for (int k = 0; k < 3; k++) step();
      chk("s4_ready_done", 32'(in_ready), 0);
      chk_stats("s4", 64, 0, 0, 0, 1);
      in_valid = 1'b0;

      // Mid-window reset
      pulse_start();
      for (int i = 0; i < 30; i++)
         send(6'(i), 4'd0);
      step();
      chk("s5_pre_cnt", 32'(sample_cnt), 30);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_ready", 32'(in_ready), 0);
      chk("s5_rst_busy",  32'(busy),     0);
      chk("s5_rst_done",  32'(done),     0);
      chk_stats("s5_rst", 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      pulse_start();
      sweep(0);
      wait_done();
      chk_stats("s5", 64, 0, 0, 0, 1);

      // Saturation on the long window
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      in_valid2 = 1'b1;
      budget = 0;
      while (!done2 && budget < 71000) begin
         step();
         budget++;
      end
      in_valid2 = 1'b0;
      chk("s6_done",       32'(done2),       1);
      chk("s6_sample_cnt", 32'(sample_cnt2), 32'h0000FFFF);
      chk("s6_viol_cnt",   32'(viol_cnt2),   32'h0000FFFF);
      chk("s6_max_err",    32'(max_err2),    12);
      chk("s6_err_sum",    32'(err_sum2),    840000);
      chk("s6_pass",       32'(pass2),       0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
